// File: rtl/vliw_regfile_np.sv
// ============================================================================
//  Module      : vliw_regfile_np
//  Description : Multi-issue VLIW register file. NPIPE pipes, each with two
//                opcode-qualified read ports and one write port, followed by
//                a single registered read stage with flush and stall.
//                Optional feature macro: RF_BYPASS_EN (same-cycle write data
//                is forwarded to reads of the same register).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vliw_regfile_np #(
  parameter int NPIPE   = 3,
  parameter int DW      = 64,
  parameter int NREG    = 16,
  parameter int AW      = 4,
  parameter int SHAMT_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                stall,
  input  logic [NPIPE*4-1:0]  f2dr_inst,
  input  logic [NPIPE*AW-1:0] f2r_src1,
  input  logic [NPIPE*AW-1:0] f2r_src2,
  input  logic [NPIPE-1:0]    w2r_wr,
  input  logic [NPIPE*AW-1:0] w2r_dest,
  input  logic [NPIPE*DW-1:0] w2r_data,
  output logic [NPIPE*DW-1:0] r2e_src1data,
  output logic [NPIPE*DW-1:0] r2e_src2data,
  output logic [NPIPE*AW-1:0] r2e_src1,
  output logic [NPIPE*AW-1:0] r2e_src2,
  output logic [NPIPE-1:0]    r2e_valid,
  output logic                wr_conflict
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_LOAD = 4'h4;
  localparam logic [3:0] OP_MOVE = 4'h5;
  localparam logic [3:0] OP_READ = 4'h6;
  localparam logic [3:0] OP_CMP  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_NAND = 4'h9;
  localparam logic [3:0] OP_NOR  = 4'hA;
  localparam logic [3:0] OP_NOT  = 4'hB;
  localparam logic [3:0] OP_SHL  = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_BSHL = 4'hE;
  localparam logic [3:0] OP_BSHR = 4'hF;

  // Low half of a word for multiply operands; low SHAMT_W bits for shift amounts
  localparam logic [DW-1:0] MLO_MASK   = {{(DW/2){1'b0}}, {(DW/2){1'b1}}};
  localparam logic [DW:0]   SHAMT_ONE  = (DW+1)'(1) << SHAMT_W;
  localparam logic [DW-1:0] SHAMT_MASK = DW'(SHAMT_ONE - 1'b1);

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic          wr_conflict_q, wr_conflict_d;

  logic [NPIPE*DW-1:0] src1data_q, src1data_d, ld_src1data;
  logic [NPIPE*DW-1:0] src2data_q, src2data_d, ld_src2data;
  logic [NPIPE*AW-1:0] src1_q, src1_d;
  logic [NPIPE*AW-1:0] src2_q, src2_d;
  logic [NPIPE-1:0]    valid_q, valid_d, ld_valid;

  // Array update: pipes applied in ascending order so the highest pipe wins a shared dest
  always_comb begin
    rf_d = rf_q;
    for (int p = 0; p < NPIPE; p++) begin
      if (w2r_wr[p]) begin
        rf_d[w2r_dest[p*AW +: AW]] = w2r_data[p*DW +: DW];
      end
    end
  end

  // Sticky flag raised when any two enabled pipes target the same dest
  always_comb begin
    wr_conflict_d = wr_conflict_q;
    for (int a = 0; a < NPIPE; a++) begin
      for (int b = a + 1; b < NPIPE; b++) begin
        if (w2r_wr[a] && w2r_wr[b] &&
            (w2r_dest[a*AW +: AW] == w2r_dest[b*AW +: AW])) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  generate
    for (genvar gp = 0; gp < NPIPE; gp++) begin : g_pipe
      logic [3:0]    op;
      logic [AW-1:0] s1, s2;
      logic [DW-1:0] rd1, rd2;
      logic [DW-1:0] op1, op2;
      logic          vld;

      assign op = f2dr_inst[gp*4 +: 4];
      assign s1 = f2r_src1[gp*AW +: AW];
      assign s2 = f2r_src2[gp*AW +: AW];

      // Raw operand fetch from the pre-write array, optionally forwarding same-cycle writes
      always_comb begin
        rd1 = rf_q[s1];
        rd2 = rf_q[s2];
`ifdef RF_BYPASS_EN
        for (int w = 0; w < NPIPE; w++) begin
          if (w2r_wr[w] && (w2r_dest[w*AW +: AW] == s1)) rd1 = w2r_data[w*DW +: DW];
          if (w2r_wr[w] && (w2r_dest[w*AW +: AW] == s2)) rd2 = w2r_data[w*DW +: DW];
        end
`endif
      end

      // Opcode qualification: zero unused operands, mask mul and shift operands
      always_comb begin
        op1 = '0;
        op2 = '0;
        vld = (op != OP_NOP);
        case (op)
          OP_ADD, OP_SUB, OP_CMP, OP_XOR, OP_NAND, OP_NOR: begin
            op1 = rd1;
            op2 = rd2;
          end
          OP_MUL: begin
            op1 = rd1 & MLO_MASK;
            op2 = rd2 & MLO_MASK;
          end
          OP_MOVE, OP_READ, OP_NOT: begin
            op1 = rd1;
          end
          OP_SHL, OP_SHR, OP_BSHL, OP_BSHR: begin
            op1 = rd1;
            op2 = rd2 & SHAMT_MASK;
          end
          OP_NOP, OP_LOAD: begin
            op1 = '0;
            op2 = '0;
          end
          default: begin
            op1 = '0;
            op2 = '0;
          end
        endcase
      end

      assign ld_src1data[gp*DW +: DW] = op1;
      assign ld_src2data[gp*DW +: DW] = op2;
      assign ld_valid[gp]             = vld;
    end
  endgenerate

  // Read-stage next state: flush beats stall beats normal load
  always_comb begin
    src1data_d = src1data_q;
    src2data_d = src2data_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    valid_d    = valid_q;
    if (flush) begin
      src1data_d = '0;
      src2data_d = '0;
      src1_d     = '0;
      src2_d     = '0;
      valid_d    = '0;
    end else if (!stall) begin
      src1data_d = ld_src1data;
      src2data_d = ld_src2data;
      src1_d     = f2r_src1;
      src2_d     = f2r_src2;
      valid_d    = ld_valid;
    end
  end

  // Register array and conflict flag; writes ignore flush and stall
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) rf_q[r] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      rf_q          <= rf_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Read-stage output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src1data_q <= '0;
      src2data_q <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      valid_q    <= '0;
    end else begin
      src1data_q <= src1data_d;
      src2data_q <= src2data_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      valid_q    <= valid_d;
    end
  end

  assign r2e_src1data = src1data_q;
  assign r2e_src2data = src2data_q;
  assign r2e_src1     = src1_q;
  assign r2e_src2     = src2_q;
  assign r2e_valid    = valid_q;
  assign wr_conflict  = wr_conflict_q;

endmodule

`default_nettype wire
